decode_stage: RTL and testbench

//  Decode stage directly upstream of the 16x32 register file. Takes ARM data-processing

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/reg_scoreboard.sv | 38 +++
 rtl/decode_stage.sv | 105 ++++++++++
 tb/tb_decode_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions: ALU opcodes, condition codes, default widths,
// the data-processing instruction layout and the immediate rotator.
package cpu_pkg;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NREGS = 16;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Data-processing instruction word, MSB first.
  typedef struct packed {
    logic [3:0]  cond;       // [31:28]
    logic [1:0]  op_class;   // [27:26], 00 for data processing
    logic        imm;        // [25] I bit
    logic [3:0]  opcode;     // [24:21]
    logic        set_flags;  // [20] S bit
    logic [3:0]  rn;         // [19:16]
    logic [3:0]  rd;         // [15:12]
    logic [11:0] operand2;   // [11:0] rot4/imm8 or shift/Rm
  } dp_instr_t;

  // Immediate operand: zero-extended imm8 rotated right by twice rot4.
  function automatic logic [31:0] rotate_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] dbl;
    dbl = {24'b0, imm8, 24'b0, imm8} >> {rot, 1'b0};
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writing instruction issues, cleared by writeback or by a flushed bundle.
module reg_scoreboard import cpu_pkg::*; #(
  parameter int AW    = cpu_pkg::AW,
  parameter int NREGS = cpu_pkg::NREGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             flush_clr_en,
  input  logic [AW-1:0]    flush_clr_addr,
  output logic [NREGS-1:0] pending
);

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // Build one-hot set/clear masks from the three request ports.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    set_mask = '0;
    clr_mask = '0;
    if (set_en)       set_mask[set_addr]       = 1'b1;
    if (clr_en)       clr_mask[clr_addr]       = 1'b1;
    if (flush_clr_en) clr_mask[flush_clr_addr] = 1'b1;
  end

  // Apply clears then sets, so a same-cycle set on the same bit wins.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values; the vector is small enough to reset.
    if (!rst) pending <= '0;
    else      pending <= (pending & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: drives register-file read addresses, detects RAW/WAW hazards
// against the scoreboard and registers a decoded bundle for execute.
module decode_stage import cpu_pkg::*; #(
  parameter int DW    = cpu_pkg::DW,
  parameter int AW    = cpu_pkg::AW,
  parameter int NREGS = cpu_pkg::NREGS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  output logic          id_ready,
  output logic [AW-1:0] read_addr1,
  output logic [AW-1:0] read_addr2,
  input  logic [DW-1:0] read_data1,
  input  logic [DW-1:0] read_data2,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [DW-1:0] ex_pc,
  output logic [3:0]    ex_cond,
  output logic [3:0]    ex_opcode,
  output logic          ex_set_flags,
  output logic [AW-1:0] ex_rd,
  output logic          ex_wb_en,
  output logic [DW-1:0] ex_op_a,
  output logic [DW-1:0] ex_op_b,
  output logic          ex_illegal,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic          flush
);

  dp_instr_t        instr;
  logic [AW-1:0]    rm;
  logic             uses_rn;
  logic             uses_rm;
  logic             illegal;
  logic             wb_en;
  logic             hazard;
  logic             issue;
  logic [DW-1:0]    op_b_next;
  logic [NREGS-1:0] sb;

  assign instr      = dp_instr_t'(if_instr);
  assign rm         = instr.operand2[3:0];
  assign read_addr1 = instr.rn;
  assign read_addr2 = rm;

  // Field decode, hazard check and operand-B selection.
  always_comb begin
    uses_rn   = !((instr.opcode == OP_MOV) || (instr.opcode == OP_MVN));
    uses_rm   = !instr.imm;
    illegal   = (instr.op_class != 2'b00) || (!instr.imm && (instr.operand2[11:4] != 8'h00));
    // TST/TEQ/CMP/CMN (10xx) only update flags; illegal encodings never write.
    wb_en     = !illegal && (instr.opcode[3:2] != 2'b10);
    // Registered scoreboard only: a same-cycle writeback does not unblock.
    hazard    = (uses_rn && sb[instr.rn]) || (uses_rm && sb[rm]) || (wb_en && sb[instr.rd]);
    id_ready  = !flush && !hazard && (!ex_valid || ex_ready);
    issue     = if_valid && id_ready;
    op_b_next = instr.imm ? DW'(rotate_imm(instr.operand2[7:0], instr.operand2[11:8])) : read_data2;
  end

  reg_scoreboard #(.AW(AW), .NREGS(NREGS)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .set_en        (issue && wb_en),
    .set_addr      (instr.rd),
    .clr_en        (wb_valid),
    .clr_addr      (wb_addr),
    .flush_clr_en  (flush && ex_valid && ex_wb_en),
    .flush_clr_addr(ex_rd),
    .pending       (sb)
  );

  // Output bundle: load on issue, drop when consumed or flushed, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_cond      <= '0;
      ex_opcode    <= '0;
      ex_set_flags <= 1'b0;
      ex_rd        <= '0;
      ex_wb_en     <= 1'b0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_illegal   <= 1'b0;
    end else if (issue) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_cond      <= instr.cond;
      ex_opcode    <= instr.opcode;
      ex_set_flags <= instr.set_flags;
      ex_rd        <= instr.rd;
      ex_wb_en     <= wb_en;
      ex_op_a      <= read_data1;
      ex_op_b      <= op_b_next;
      ex_illegal   <= illegal;
    end else if (flush || ex_ready) begin
      ex_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a fixed-pattern register-file model.
module tb_decode_stage;
  import cpu_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          id_ready;
  logic [3:0]    read_addr1;
  logic [3:0]    read_addr2;
  logic [31:0]   read_data1;
  logic [31:0]   read_data2;
  logic          ex_valid;
  logic          ex_ready;
  logic [31:0]   ex_pc;
  logic [3:0]    ex_cond;
  logic [3:0]    ex_opcode;
  logic          ex_set_flags;
  logic [3:0]    ex_rd;
  logic          ex_wb_en;
  logic [31:0]   ex_op_a;
  logic [31:0]   ex_op_b;
  logic          ex_illegal;
  logic          wb_valid;
  logic [3:0]    wb_addr;
  logic          flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Register file model: port 1 returns A000_000n, port 2 returns B000_000n.
  assign read_data1 = {28'hA000000, read_addr1};
  assign read_data2 = {28'hB000000, read_addr2};

  decode_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_cond(ex_cond),
    .ex_opcode(ex_opcode), .ex_set_flags(ex_set_flags), .ex_rd(ex_rd),
    .ex_wb_en(ex_wb_en), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_illegal(ex_illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_op_b", ex_op_b, 0);
    check("rst_sb", dut.sb, 0);
    tick();
    rst = 1'b1;

    // 1: ADD r3,r1,r2
    if_valid = 1'b1; if_instr = 32'hE0813002; if_pc = 32'h0000_0100;
    #1;
    check("t1_raddr1", read_addr1, 1);
    check("t1_raddr2", read_addr2, 2);
    check("t1_id_ready", id_ready, 1);
    tick();
    check("t1_ex_valid", ex_valid, 1);
    check("t1_ex_rd", ex_rd, 3);
    check("t1_ex_pc", ex_pc, 32'h0000_0100);
    check("t1_ex_cond", ex_cond, 4'hE);
    check("t1_ex_opcode", ex_opcode, 4'h4);
    check("t1_ex_op_a", ex_op_a, 32'hA000_0001);
    check("t1_ex_op_b", ex_op_b, 32'hB000_0002);
    check("t1_ex_wb_en", ex_wb_en, 1);
    check("t1_sb", dut.sb, 16'h0008);

    // 2: MOV r0,#0xFF000000, issues back-to-back
    if_instr = 32'hE3A004FF; if_pc = 32'h0000_0104;
    #1;
    check("t2_id_ready", id_ready, 1);
    tick();
    check("t2_ex_op_b", ex_op_b, 32'hFF00_0000);
    check("t2_ex_wb_en", ex_wb_en, 1);
    check("t2_ex_opcode", ex_opcode, 4'hD);
    check("t2_ex_pc", ex_pc, 32'h0000_0104);
    check("t2_sb", dut.sb, 16'h0009);
    if_valid = 1'b0; wb_valid = 1'b1; wb_addr = 4'd0;
    tick();
    wb_valid = 1'b0;
    check("t2_sb_wb", dut.sb, 16'h0008);
    check("t2_ex_valid_drop", ex_valid, 0);

    // 3: SUB r4,r3,r1 stalls on r3 until writeback has retired it
    if_valid = 1'b1; if_instr = 32'hE0434001; if_pc = 32'h0000_0108;
    #1;
    check("t3_stall", id_ready, 0);
    tick();
    check("t3_no_issue", ex_valid, 0);
    wb_valid = 1'b1; wb_addr = 4'd3;
    #1;
    check("t3_no_bypass", id_ready, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("t3_sb_clr", dut.sb, 0);
    check("t3_ready", id_ready, 1);
    tick();
    check("t3_ex_rd", ex_rd, 4);
    check("t3_ex_opcode", ex_opcode, 4'h2);
    check("t3_ex_op_a", ex_op_a, 32'hA000_0003);
    check("t3_ex_op_b", ex_op_b, 32'hB000_0001);
    check("t3_sb", dut.sb, 16'h0010);

    // 4: backpressure holds the bundle, then ORR r6,r7,#1 issues same cycle
    ex_ready = 1'b0; if_instr = 32'hE3876001; if_pc = 32'h0000_010C;
    #1;
    check("t4_bp_ready", id_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_valid", ex_valid, 1);
      check("t4_hold_rd", ex_rd, 4);
      check("t4_hold_op_a", ex_op_a, 32'hA000_0003);
      check("t4_hold_pc", ex_pc, 32'h0000_0108);
      check("t4_hold_ready", id_ready, 0);
    end
    ex_ready = 1'b1;
    #1;
    check("t4_release_ready", id_ready, 1);
    tick();
    check("t4_ex_rd", ex_rd, 6);
    check("t4_ex_op_a", ex_op_a, 32'hA000_0007);
    check("t4_ex_op_b", ex_op_b, 32'h0000_0001);
    check("t4_ex_opcode", ex_opcode, 4'hC);
    check("t4_sb", dut.sb, 16'h0050);

    // 5: CMP r1,r2 sets nothing; flushed ADD r5 releases its bit
    if_instr = 32'hE1510002; if_pc = 32'h0000_0110;
    #1;
    check("t5_cmp_ready", id_ready, 1);
    tick();
    check("t5_cmp_wb_en", ex_wb_en, 0);
    check("t5_cmp_s", ex_set_flags, 1);
    check("t5_cmp_opcode", ex_opcode, 4'hA);
    check("t5_cmp_sb", dut.sb, 16'h0050);
    if_instr = 32'hE0815002; if_pc = 32'h0000_0114;
    tick();
    check("t5_add_rd", ex_rd, 5);
    check("t5_add_sb", dut.sb, 16'h0070);
    ex_ready = 1'b0; flush = 1'b1; if_instr = 32'hE0818002;
    #1;
    check("t5_flush_ready", id_ready, 0);
    tick();
    flush = 1'b0;
    check("t5_flush_valid", ex_valid, 0);
    check("t5_flush_sb", dut.sb, 16'h0050);
    ex_ready = 1'b1; if_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd4;
    tick();
    wb_addr = 4'd6;
    tick();
    wb_valid = 1'b0;
    check("t5_sb_drained", dut.sb, 0);

    // Same-bit set and clear in one cycle: set wins
    if_valid = 1'b1; if_instr = 32'hE0816002; wb_valid = 1'b1; wb_addr = 4'd6;
    tick();
    check("set_wins_sb", dut.sb, 16'h0040);
    check("set_wins_rd", ex_rd, 6);
    if_valid = 1'b0; wb_addr = 4'd6;
    tick();
    wb_valid = 1'b0;
    check("set_wins_clr", dut.sb, 0);

    // 6: LDR and shifted-register ADD are illegal and set nothing
    if_valid = 1'b1; if_instr = 32'hE5912000; if_pc = 32'h0000_0120;
    tick();
    check("t6_ldr_valid", ex_valid, 1);
    check("t6_ldr_illegal", ex_illegal, 1);
    check("t6_ldr_wb_en", ex_wb_en, 0);
    check("t6_ldr_sb", dut.sb, 0);
    if_instr = 32'hE0821103; if_pc = 32'h0000_0124;
    tick();
    check("t6_lsl_illegal", ex_illegal, 1);
    check("t6_lsl_wb_en", ex_wb_en, 0);
    check("t6_lsl_sb", dut.sb, 0);
    if_instr = 32'hE0813002;
    tick();
    check("t6_legal_illegal", ex_illegal, 0);
    check("t6_legal_sb", dut.sb, 16'h0008);

    // Asynchronous reset while stalled
    if_instr = 32'hE0434001; ex_ready = 1'b0;
    #1;
    check("rst2_stalled", id_ready, 0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("rst2_ex_valid", ex_valid, 0);
    check("rst2_ex_rd", ex_rd, 0);
    check("rst2_ex_op_a", ex_op_a, 0);
    check("rst2_ex_op_b", ex_op_b, 0);
    check("rst2_ex_pc", ex_pc, 0);
    check("rst2_ex_wb_en", ex_wb_en, 0);
    check("rst2_sb", dut.sb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
